logic_reduce_seq: RTL

- Parametrised, multi-cycle successor to the fixed 6-input reduction gates.
- Reduces a WIDTH-bit operand to one bit using a run-time selected function: AND, NAND, OR, NOR, XOR or XNOR.
- Folds CHUNK bits per cycle, so wide operands meet timing in the datapath.
- Uses a valid/ready handshake on both input and output; one operation is in flight at a time.

---
 rtl/logic_expr_pkg.sv | 36 +++
 rtl/chunk_fold.sv | 28 ++
 rtl/logic_reduce_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/logic_expr_pkg.sv
// Shared definitions for the sequential logic-reduction block.
// Holds the function-select encoding, its identity / inversion / reserved
// helpers, and the FSM state constants.
package logic_expr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_AND  = 3'd0;
  localparam mode_t MODE_NAND = 3'd1;
  localparam mode_t MODE_OR   = 3'd2;
  localparam mode_t MODE_NOR  = 3'd3;
  localparam mode_t MODE_XOR  = 3'd4;
  localparam mode_t MODE_XNOR = 3'd5;
  // Encodings 6 and 7 are reserved.

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StReduce = 2'd1;
  localparam state_t StDone   = 2'd2;

  // Value that leaves the accumulator unchanged for the selected function.
  function automatic logic mode_identity(input mode_t mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

  // Final result is the complement of the accumulated value.
  function automatic logic mode_inverts(input mode_t mode);
    return (mode == MODE_NAND) || (mode == MODE_NOR) || (mode == MODE_XNOR);
  endfunction

  function automatic logic mode_reserved(input mode_t mode);
    return mode > MODE_XNOR;
  endfunction

endpackage

// File: rtl/chunk_fold.sv
// Combinational fold of one CHUNK-bit slice to a single bit.
//   chunk_i : operand bits of this slice
//   pad_i   : 1 marks a bit beyond the operand width (treated as identity)
//   mode_i  : function select
//   fold_o  : AND/OR/XOR reduction of the slice (before any final inversion)
module chunk_fold
  import logic_expr_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] chunk_i,
  input  logic [CHUNK-1:0] pad_i,
  input  mode_t            mode_i,
  output logic             fold_o
);

  always_comb begin
    fold_o = 1'b0;
    case (mode_i)
      // Padding forced to 1 for AND, to 0 for OR/XOR, so it never matters.
      MODE_AND, MODE_NAND: fold_o = &(chunk_i | pad_i);
      MODE_OR,  MODE_NOR:  fold_o = |(chunk_i & ~pad_i);
      MODE_XOR, MODE_XNOR: fold_o = ^(chunk_i & ~pad_i);
      default:             fold_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_reduce_seq.sv
// Multi-cycle WIDTH-bit to 1-bit logic reduction, CHUNK bits folded per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (in_data, in_mode)
//   out_valid/out_ready   : result handshake (out_result, out_err)
//   busy                  : high whenever not idle
module logic_reduce_seq
  import logic_expr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned SPAN   = NCHUNK * CHUNK;
  localparam int unsigned IW     = $clog2(NCHUNK) + 1;

  state_t          state_q, state_d;
  logic [SPAN-1:0] data_q, data_d;
  logic [SPAN-1:0] pad_q, pad_d;
  mode_t           mode_q, mode_d;
  logic            acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            result_q, result_d;
  logic            err_q, err_d;

  logic [SPAN-1:0] data_ext, pad_ext;
  logic            fold;
  logic            acc_next;

  // Operand widened to whole chunks; pad_ext flags the bits past WIDTH.
  always_comb begin
    data_ext              = '0;
    data_ext[WIDTH-1:0]   = in_data;
    pad_ext               = '1;
    pad_ext[WIDTH-1:0]    = '0;
  end

  // Data and pad mask shift down so the current chunk is always the low slice.
  chunk_fold #(
    .CHUNK(CHUNK)
  ) u_chunk_fold (
    .chunk_i(data_q[CHUNK-1:0]),
    .pad_i  (pad_q[CHUNK-1:0]),
    .mode_i (mode_q),
    .fold_o (fold)
  );

  always_comb begin
    acc_next = 1'b0;
    case (mode_q)
      MODE_AND, MODE_NAND: acc_next = acc_q & fold;
      MODE_OR,  MODE_NOR:  acc_next = acc_q | fold;
      MODE_XOR, MODE_XNOR: acc_next = acc_q ^ fold;
      default:             acc_next = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    pad_d    = pad_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = data_ext;
          pad_d   = pad_ext;
          mode_d  = in_mode;
          acc_d   = mode_identity(in_mode);
          idx_d   = '0;
          err_d   = mode_reserved(in_mode);
          state_d = StReduce;
        end
      end
      StReduce: begin
        acc_d  = acc_next;
        data_d = data_q >> CHUNK;
        pad_d  = pad_q >> CHUNK;
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(NCHUNK - 1)) begin
          result_d = mode_reserved(mode_q) ? 1'b0 : (acc_next ^ mode_inverts(mode_q));
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      pad_q    <= '0;
      mode_q   <= MODE_AND;
      acc_q    <= 1'b0;
      idx_q    <= '0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      pad_q    <= pad_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule
